// File: rtl/stopwatch_control_fsm.sv
// Stopwatch control: synchronizes and debounces three raw buttons, then runs the
// start/stop/lap/reset state machine and a display-refresh request handshake.

module stopwatch_debounce #(
  parameter int CYCLES = 1000
) (
  input  logic clk,
  input  logic res,
  input  logic ena,
  input  logic btn,
  output logic level
);
  localparam int CW = $clog2(CYCLES + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
    end else if (ena) begin
      sync <= {sync[0], btn};
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(CYCLES - 1)) begin
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module stopwatch_control_fsm #(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int REFRESH_CYCLES  = 10000
) (
  input  logic       clk,
  input  logic       res,
  input  logic       ena,
  input  logic       i_start_stop,
  input  logic       i_lap,
  input  logic       i_reset,
  input  logic       i_disp_ack,
  output logic       o_count_en,
  output logic       o_count_clr,
  output logic       o_lap_capture,
  output logic       o_lap_hold,
  output logic       o_disp_req,
  output logic [2:0] o_state
);
  localparam int NUM_BTN = 3;
  localparam int RW      = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int B_SS    = 0;
  localparam int B_LAP   = 1;
  localparam int B_RST   = 2;

  typedef enum logic [2:0] {
    CLEARED     = 3'd0,
    RUNNING     = 3'd1,
    STOPPED     = 3'd2,
    LAP_RUNNING = 3'd3,
    LAP_STOPPED = 3'd4
  } state_t;

  logic [NUM_BTN-1:0] raw, lvl, lvl_d, press_q;
  state_t             state, state_nxt;
  logic               clr_nxt, cap_nxt;
  logic [RW-1:0]      rcnt;
  logic               wrap, trig_q;

  assign raw = {i_reset, i_lap, i_start_stop};

  for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
    stopwatch_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk  (clk),
      .res  (res),
      .ena  (ena),
      .btn  (raw[b]),
      .level(lvl[b])
    );
  end

  // Reset outranks start/stop, which outranks lap; losers in the same cycle are dropped.
  always_comb begin
    state_nxt = state;
    clr_nxt   = 1'b0;
    cap_nxt   = 1'b0;
    if (press_q[B_RST]) begin
      state_nxt = CLEARED;
      clr_nxt   = 1'b1;
    end else if (press_q[B_SS]) begin
      case (state)
        CLEARED:     state_nxt = RUNNING;
        RUNNING:     state_nxt = STOPPED;
        STOPPED:     state_nxt = RUNNING;
        LAP_RUNNING: state_nxt = LAP_STOPPED;
        LAP_STOPPED: state_nxt = LAP_RUNNING;
        default:     state_nxt = CLEARED;
      endcase
    end else if (press_q[B_LAP]) begin
      case (state)
        CLEARED:     state_nxt = CLEARED;
        STOPPED:     state_nxt = STOPPED;
        RUNNING: begin
          state_nxt = LAP_RUNNING;
          cap_nxt   = 1'b1;
        end
        LAP_RUNNING: state_nxt = RUNNING;
        LAP_STOPPED: state_nxt = STOPPED;
        default:     state_nxt = CLEARED;
      endcase
    end else if (state > LAP_STOPPED) begin
      state_nxt = CLEARED;
    end
  end

  assign wrap    = (rcnt == RW'(REFRESH_CYCLES - 1));
  assign o_state = state;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      lvl_d         <= '0;
      press_q       <= '0;
      state         <= CLEARED;
      o_count_en    <= 1'b0;
      o_count_clr   <= 1'b0;
      o_lap_capture <= 1'b0;
      o_lap_hold    <= 1'b0;
      o_disp_req    <= 1'b0;
      rcnt          <= '0;
      trig_q        <= 1'b0;
    end else if (ena) begin
      lvl_d         <= lvl;
      press_q       <= lvl & ~lvl_d;
      state         <= state_nxt;
      o_count_clr   <= clr_nxt;
      o_lap_capture <= cap_nxt;
      o_count_en    <= (state_nxt == RUNNING) || (state_nxt == LAP_RUNNING);
      o_lap_hold    <= (state_nxt == LAP_RUNNING) || (state_nxt == LAP_STOPPED);
      rcnt          <= wrap ? '0 : rcnt + 1'b1;
      trig_q        <= (state_nxt != state) || wrap;
      // A trigger landing on the ack edge re-arms the request instead of being lost.
      o_disp_req    <= trig_q || (o_disp_req && !i_disp_ack);
    end else begin
      o_count_en    <= 1'b0;
      o_count_clr   <= 1'b0;
      o_lap_capture <= 1'b0;
    end
  end
endmodule

// File: tb/tb_stopwatch_control_fsm.sv
// Scoreboard bench: scenarios push time-stamped expected output snapshots; a
// negedge monitor pops and compares them independently of the stimulus.

module tb_stopwatch_control_fsm;
  localparam int D = 4;
  localparam int R = 16;
  localparam logic [7:0] MF = 8'hEF;  // everything except o_disp_req
  localparam logic [7:0] MQ = 8'h10;  // o_disp_req only
  localparam logic [7:0] MA = 8'hFF;

  logic clk = 1'b0, res = 1'b0, ena = 1'b1;
  logic ss = 1'b0, lap = 1'b0, rb = 1'b0, ack = 1'b1;
  logic o_count_en, o_count_clr, o_lap_capture, o_lap_hold, o_disp_req;
  logic [2:0] o_state;

  stopwatch_control_fsm #(.DEBOUNCE_CYCLES(D), .REFRESH_CYCLES(R)) dut (
    .clk          (clk),
    .res          (res),
    .ena          (ena),
    .i_start_stop (ss),
    .i_lap        (lap),
    .i_reset      (rb),
    .i_disp_ack   (ack),
    .o_count_en   (o_count_en),
    .o_count_clr  (o_count_clr),
    .o_lap_capture(o_lap_capture),
    .o_lap_hold   (o_lap_hold),
    .o_disp_req   (o_disp_req),
    .o_state      (o_state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [7:0] mask;
    logic [7:0] val;
    string      name;
  } exp_t;

  exp_t q[$];
  int   base = 0;
  int   errors = 0;
  int   checks = 0;

  wire [7:0] ov = {o_state, o_disp_req, o_lap_hold, o_lap_capture, o_count_clr, o_count_en};

  function automatic void chk(string name, logic [7:0] mask, logic [7:0] got, logic [7:0] want);
    checks++;
    if ((got & mask) !== (want & mask)) begin
      errors++;
      $display("FAIL %s: got %b want %b (mask %b, state/req/hold/cap/clr/en)",
               name, got & mask, want & mask, mask);
    end
  endfunction

  function automatic void ex(int t, logic [7:0] m, logic [2:0] st, logic req, logic hold,
                             logic cap, logic clr, logic en, string n);
    exp_t e;
    e.cyc  = base + t;
    e.mask = m;
    e.val  = {st, req, hold, cap, clr, en};
    e.name = n;
    q.push_back(e);
  endfunction

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      e = q.pop_front();
      if (e.cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL %s: sample at cycle %0d missed, now %0d", e.name, e.cyc, cyc);
      end else begin
        chk(e.name, e.mask, ov, e.val);
      end
    end
  end

  task automatic do_res();
    @(posedge clk);
    #1 res = 1'b1;
    #1 chk("reset_async", MA, ov, 8'h00);
    @(posedge clk);
    #1 res = 1'b0;
    base = cyc;
  endtask

  task automatic wait_to(int t);
    while (cyc < base + t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    #1;
    if (q.size() > 0) begin
      $display("FAIL drain_timeout: got %0d pending want 0", q.size());
      errors += q.size();
      checks += q.size();
      q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Press start, lap glitch, lap/stop/lap sequence
    ack = 1'b1;
    do_res();
    ex( 7, MF, 3'd0, 0, 0, 0, 0, 0, "A_before_latency");
    ex( 8, MF, 3'd1, 0, 0, 0, 0, 1, "A_running");
    ex( 9, MA, 3'd1, 1, 0, 0, 0, 1, "A_req_on_change");
    ex(10, MA, 3'd1, 0, 0, 0, 0, 1, "A_req_acked");
    ex(28, MF, 3'd1, 0, 0, 0, 0, 1, "B_glitch_28");
    ex(30, MF, 3'd1, 0, 0, 0, 0, 1, "B_glitch_30");
    ex(42, MF, 3'd1, 0, 0, 0, 0, 1, "C_before_lap");
    ex(43, MF, 3'd3, 0, 1, 1, 0, 1, "C_lap_capture");
    ex(44, MF, 3'd3, 0, 1, 0, 0, 1, "C_capture_one_cycle");
    ex(57, MF, 3'd3, 0, 1, 0, 0, 1, "C_before_stop");
    ex(58, MF, 3'd4, 0, 1, 0, 0, 0, "C_lap_stopped");
    ex(72, MF, 3'd4, 0, 1, 0, 0, 0, "C_before_lap2");
    ex(73, MF, 3'd2, 0, 0, 0, 0, 0, "C_stopped");
    ss = 1'b1;
    wait_to(10); ss  = 1'b0;
    wait_to(20); lap = 1'b1;
    wait_to(23); lap = 1'b0;
    wait_to(35); lap = 1'b1;
    wait_to(41); lap = 1'b0;
    wait_to(50); ss  = 1'b1;
    wait_to(56); ss  = 1'b0;
    wait_to(65); lap = 1'b1;
    wait_to(71); lap = 1'b0;
    drain();

    // All buttons together while running, then reset while already cleared
    do_res();
    ex( 8, MF, 3'd1, 0, 0, 0, 0, 1, "D_running");
    ex(22, MF, 3'd1, 0, 0, 0, 0, 1, "D_before_triple");
    ex(23, MF, 3'd0, 0, 0, 0, 1, 0, "D_triple_clear");
    ex(24, MF, 3'd0, 0, 0, 0, 0, 0, "D_clear_one_cycle");
    ex(37, MF, 3'd0, 0, 0, 0, 0, 0, "D_idle");
    ex(38, MF, 3'd0, 0, 0, 0, 1, 0, "D_clear_in_cleared");
    ex(39, MF, 3'd0, 0, 0, 0, 0, 0, "D_clear2_one_cycle");
    ss = 1'b1;
    wait_to(6);  ss = 1'b0;
    wait_to(15); ss = 1'b1; lap = 1'b1; rb = 1'b1;
    wait_to(21); ss = 1'b0; lap = 1'b0; rb = 1'b0;
    wait_to(30); rb = 1'b1;
    wait_to(36); rb = 1'b0;
    drain();

    // Refresh request handshake driven by the free-running counter
    ack = 1'b0;
    do_res();
    ex(16, MQ, 3'd0, 0, 0, 0, 0, 0, "E_req_before_wrap");
    ex(17, MQ, 3'd0, 1, 0, 0, 0, 0, "E_req_after_wrap");
    ex(40, MQ, 3'd0, 1, 0, 0, 0, 0, "E_req_held_40");
    ex(56, MQ, 3'd0, 1, 0, 0, 0, 0, "E_req_held_56");
    ex(57, MQ, 3'd0, 1, 0, 0, 0, 0, "E_req_before_ack");
    ex(58, MQ, 3'd0, 0, 0, 0, 0, 0, "E_req_acked");
    ex(64, MQ, 3'd0, 0, 0, 0, 0, 0, "E_req_idle");
    ex(65, MQ, 3'd0, 1, 0, 0, 0, 0, "E_req_next_wrap");
    ex(81, MQ, 3'd0, 1, 0, 0, 0, 0, "E_trig_on_ack_edge");
    ex(82, MQ, 3'd0, 1, 0, 0, 0, 0, "E_req_rearmed");
    ex(83, MQ, 3'd0, 0, 0, 0, 0, 0, "E_req_acked2");
    wait_to(57); ack = 1'b1;
    wait_to(58); ack = 1'b0;
    wait_to(80); ack = 1'b1;
    wait_to(81); ack = 1'b0;
    wait_to(82); ack = 1'b1;
    wait_to(83); ack = 1'b0;
    drain();

    // Enable low mid-debounce, then enable low while running
    ack = 1'b1;
    do_res();
    ex(17, MF, 3'd0, 0, 0, 0, 0, 0, "F_debounce_frozen");
    ex(18, MF, 3'd1, 0, 0, 0, 0, 1, "F_resumed_accept");
    ex(25, MF, 3'd1, 0, 0, 0, 0, 1, "F_running");
    ex(26, MF, 3'd1, 0, 0, 0, 0, 0, "F_ena_low_en0");
    ex(28, MF, 3'd1, 0, 0, 0, 0, 0, "F_ena_low_hold");
    ex(29, MF, 3'd1, 0, 0, 0, 0, 1, "F_ena_back");
    ss = 1'b1;
    wait_to(4);  ena = 1'b0;
    wait_to(14); ena = 1'b1;
    wait_to(25); ena = 1'b0;
    wait_to(28); ena = 1'b1;
    wait_to(30); ss  = 1'b0;
    drain();

    // Button already held when res releases needs a full debounce period
    ss = 1'b1;
    do_res();
    ex(7, MF, 3'd0, 0, 0, 0, 0, 0, "G_held_through_res");
    ex(8, MF, 3'd1, 0, 0, 0, 0, 1, "G_accepted");
    wait_to(12); ss = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
